// File: rtl/rv32_div_sequencer.sv
// RV32M DIV/DIVU/REM/REMU sequencer: restoring radix-2 divider, one quotient bit per cycle.
// Holds the pipeline via stall_req and pulses done with the result for one cycle.
module rv32_div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            flush,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    // Only what FIXUP needs survives IDLE: the signed flag is folded into the sign flags.
    typedef struct packed {
        logic sel_rem;
        logic neg_q;
        logic neg_r;
    } req_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    req_t            req;
    logic [XLEN-1:0] dvsr;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;

    logic            sgn;
    logic [XLEN-1:0] min_neg;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic            div_zero;
    logic            ovf;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    assign sgn      = ~op[0];
    assign min_neg  = {1'b1, {(XLEN-1){1'b0}}};
    assign mag1     = (sgn && op1[XLEN-1]) ? -op1 : op1;
    assign mag2     = (sgn && op2[XLEN-1]) ? -op2 : op2;
    assign div_zero = (op2 == '0);
    assign ovf      = sgn && (op1 == min_neg) && (op2 == '1);

    // One extra bit on the shifted remainder so the trial subtract never overflows.
    assign rem_sh   = {rem, quo[XLEN-1]};
    assign diff     = rem_sh - {1'b0, dvsr};

    assign q_fix    = req.neg_q ? -quo : quo;
    assign r_fix    = req.neg_r ? -rem : rem;

    assign stall_req = (state == IDLE && start && !flush) || state == CALC || state == FIXUP;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt    <= '0;
            req    <= '0;
            dvsr   <= '0;
            rem    <= '0;
            quo    <= '0;
            done   <= 1'b0;
            result <= '0;
        end else if (flush) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        req <= '{sel_rem: op[1],
                                 neg_q:   sgn & (op1[XLEN-1] ^ op2[XLEN-1]),
                                 neg_r:   sgn & op1[XLEN-1]};
                        if (div_zero) begin
                            result <= op[1] ? op1 : '1;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else if (ovf) begin
                            result <= op[1] ? '0 : min_neg;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            quo   <= mag1;
                            dvsr  <= mag2;
                            rem   <= '0;
                            cnt   <= CW'(XLEN);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!diff[XLEN]) begin
                        rem <= diff[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b0};
                    end
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= FIXUP;
                end
                FIXUP: begin
                    result <= req.sel_rem ? r_fix : q_fix;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_div_sequencer.sv
// Scoreboard bench for rv32_div_sequencer: expected result/latency queued at issue, checked at done.
module tb_rv32_div_sequencer;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            start = 1'b0;
    logic [1:0]      op = 2'b00;
    logic [XLEN-1:0] op1 = '0;
    logic [XLEN-1:0] op2 = '0;
    logic            flush = 1'b0;
    logic            stall_req;
    logic            done;
    logic [XLEN-1:0] result;

    rv32_div_sequencer #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .op        (op),
        .op1       (op1),
        .op2       (op2),
        .flush     (flush),
        .stall_req (stall_req),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
        string       name;
    } exp_t;

    exp_t        sb[$];
    bit          stall_hist[0:127];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_res = '0;

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                   input string nm);
        exp_t e;
        logic [31:0] q;
        logic [31:0] r;
        int sa;
        int sb_;
        e.name = nm;
        e.lat  = 34;
        if (b == 32'h0) begin
            q = 32'hFFFF_FFFF; r = a; e.lat = 1;
        end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'h0; e.lat = 1;
        end else if (!o[0]) begin
            sa = a; sb_ = b;
            q = sa / sb_;
            r = sa % sb_;
        end else begin
            q = a / b;
            r = a % b;
        end
        e.res = o[1] ? r : q;
        return e;
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input string nm, input bit push);
        @(negedge clk);
        start = 1'b1; op = o; op1 = a; op2 = b;
        if (push) sb.push_back(model(o, a, b, nm));
    endtask

    // Runs from the issue cycle (k=0) until done or limit, recording stall_req per cycle.
    task automatic wait_done(input int limit, output int lat);
        lat = -1;
        #1;
        for (int k = 0; k <= limit; k++) begin
            if (k > 0) begin
                @(negedge clk);
                if (k == 1) start = 1'b0;
                #1;
            end
            stall_hist[k] = stall_req;
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        #12;
        n_cmp++; if (done !== 1'b0)      begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall_req); end
        n_cmp++; if (result !== 32'h0)   begin n_bad++; $display("FAIL reset_result: got %h want 0", result); end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_divu_basic;
        int lat;
        exp_t e;
        issue(2'b01, 32'd100, 32'd7, "divu_100_7", 1);
        wait_done(40, lat);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL %s_lat: got %0d want %0d", e.name, lat, e.lat); end
        n_cmp++; if (result !== 32'd14) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, result, 32'd14); end
        for (int k = 0; k <= 34; k++) begin
            n_cmp++;
            if (stall_hist[k] !== (k < 34)) begin
                n_bad++; $display("FAIL divu_stall_c%0d: got %b want %b", k, stall_hist[k], (k < 34));
            end
        end
        last_res = e.res;
    endtask

    task automatic test_signed;
        int lat;
        exp_t e;
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, "rem_m7_2", 1);
        wait_done(40, lat);
        e = sb.pop_front();
        n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL %s_lat: got %0d want 34", e.name, lat); end
        n_cmp++; if (result !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL %s: got %h want ffffffff", e.name, result); end
        issue(2'b00, 32'hFFFF_FFF9, 32'd2, "div_m7_2", 1);
        wait_done(40, lat);
        e = sb.pop_front();
        n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL %s_lat: got %0d want 34", e.name, lat); end
        n_cmp++; if (result !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL %s: got %h want fffffffd", e.name, result); end
        last_res = e.res;
    endtask

    task automatic test_div_by_zero;
        int lat;
        exp_t e;
        issue(2'b00, 32'd5, 32'd0, "div_5_0", 1);
        wait_done(40, lat);
        e = sb.pop_front();
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL %s_lat: got %0d want 1", e.name, lat); end
        n_cmp++; if (result !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL %s: got %h want ffffffff", e.name, result); end
        n_cmp++; if (stall_hist[0] !== 1'b1) begin n_bad++; $display("FAIL %s_stall_c0: got %b want 1", e.name, stall_hist[0]); end
        n_cmp++; if (stall_hist[1] !== 1'b0) begin n_bad++; $display("FAIL %s_stall_c1: got %b want 0", e.name, stall_hist[1]); end
        issue(2'b11, 32'd5, 32'd0, "remu_5_0", 1);
        wait_done(40, lat);
        e = sb.pop_front();
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL %s_lat: got %0d want 1", e.name, lat); end
        n_cmp++; if (result !== 32'd5) begin n_bad++; $display("FAIL %s: got %h want 5", e.name, result); end
        last_res = e.res;
    endtask

    task automatic test_overflow;
        int lat;
        exp_t e;
        issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1);
        wait_done(40, lat);
        e = sb.pop_front();
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL %s_lat: got %0d want 1", e.name, lat); end
        n_cmp++; if (result !== 32'h8000_0000) begin n_bad++; $display("FAIL %s: got %h want 80000000", e.name, result); end
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", 1);
        wait_done(40, lat);
        e = sb.pop_front();
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL %s_lat: got %0d want 1", e.name, lat); end
        n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL %s: got %h want 0", e.name, result); end
        last_res = e.res;
    endtask

    task automatic test_flush;
        int lat;
        bit seen_done;
        exp_t e;
        seen_done = 1'b0;
        issue(2'b01, 32'd1000, 32'd3, "flushed", 0);
        #1;
        for (int k = 0; k <= 11; k++) begin
            if (k > 0) begin
                @(negedge clk);
                if (k == 1)  start = 1'b0;
                if (k == 10) flush = 1'b1;
                if (k == 11) flush = 1'b0;
                #1;
            end
            if (done) seen_done = 1'b1;
        end
        n_cmp++; if (seen_done !== 1'b0) begin n_bad++; $display("FAIL flush_no_done: got %b want 0", seen_done); end
        n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("FAIL flush_idle_stall: got %b want 0", stall_req); end
        n_cmp++; if (result !== last_res) begin n_bad++; $display("FAIL flush_result_hold: got %h want %h", result, last_res); end
        issue(2'b01, 32'd9, 32'd3, "divu_9_3_after_flush", 1);
        wait_done(40, lat);
        e = sb.pop_front();
        n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL %s_lat: got %0d want 34", e.name, lat); end
        n_cmp++; if (result !== 32'd3) begin n_bad++; $display("FAIL %s: got %h want 3", e.name, result); end
        last_res = e.res;
    endtask

    task automatic test_reset_mid_calc;
        int lat;
        exp_t e;
        issue(2'b01, 32'hFFFF_0000, 32'd3, "reset_victim", 0);
        #1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        #3;
        resetn = 1'b0;
        #1;
        n_cmp++; if (done !== 1'b0)      begin n_bad++; $display("FAIL rst_mid_done: got %b want 0", done); end
        n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("FAIL rst_mid_stall: got %b want 0", stall_req); end
        n_cmp++; if (result !== 32'h0)   begin n_bad++; $display("FAIL rst_mid_result: got %h want 0", result); end
        @(negedge clk);
        resetn = 1'b1;
        issue(2'b01, 32'hFFFF_FFFF, 32'd1, "divu_max_1", 1);
        wait_done(40, lat);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL %s_lat: got %0d want %0d", e.name, lat, e.lat); end
        n_cmp++; if (result !== e.res) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, result, e.res); end
        last_res = e.res;
    endtask

    task automatic test_back_to_back;
        int lat;
        exp_t e;
        logic [1:0]  t_op [0:5] = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 2'b11};
        logic [31:0] t_a  [0:5] = '{32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'h8000_0000, 32'd100, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] t_b  [0:5] = '{32'd7, 32'd7, 32'h10, 32'hFFFF_FFF9, 32'd2, 32'h1_0000};
        for (int i = 0; i < 10; i++) begin
            logic [1:0]  o;
            logic [31:0] a;
            logic [31:0] b;
            if (i < 6) begin
                o = t_op[i]; a = t_a[i]; b = t_b[i];
            end else begin
                o = 2'($urandom_range(3));
                a = $urandom;
                b = (i == 8) ? 32'($urandom_range(15)) : ($urandom >> $urandom_range(31));
            end
            issue(o, a, b, $sformatf("b2b_%0d", i), 1);
            wait_done(40, lat);
            e = sb.pop_front();
            n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL %s_lat: got %0d want %0d (op=%b a=%h b=%h)", e.name, lat, e.lat, o, a, b); end
            n_cmp++; if (result !== e.res) begin n_bad++; $display("FAIL %s: got %h want %h (op=%b a=%h b=%h)", e.name, result, e.res, o, a, b); end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_div_by_zero();
        test_overflow();
        test_flush();
        test_reset_mid_calc();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rv32_div_sequencer.md
Name: rv32_div_sequencer

Overview:
- Multi-cycle integer divide controller and iterative datapath for the exec stage.
- Implements RV32M DIV/DIVU/REM/REMU as a restoring radix-2 divider, one quotient bit per cycle.
- Raises a stall request that the core ORs into the pipeline stop while a divide is in flight.
- Presents the result for exactly one cycle so the exec buffer can capture it.

Parameters:
- XLEN, 32, operand and result width; counter width is $clog2(XLEN+1).

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- start  in  1  exec stage holds a divide instruction (level; sampled only in IDLE)
- op  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- op1  in  XLEN  dividend (post-bypass rs1)
- op2  in  XLEN  divisor (post-bypass rs2)
- flush  in  1  abort in-flight divide (branch/jump squash)
- stall_req  out  1  hold pipeline; combinational
- done  out  1  result valid this cycle
- result  out  XLEN  quotient or remainder

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, counter=0, done=0, result=0, all internal registers 0. An active resetn mid-divide discards the operation; no done is produced.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE, start=1, flush=0:
  - Latch op and the signed/unsigned flag (op[0]=0 means signed).
  - Latch magnitudes |op1| and |op2| (raw values if unsigned).
  - Latch neg_q = signed & (op1[XLEN-1]^op2[XLEN-1]) and neg_r = signed & op1[XLEN-1].
- Special cases, detected in IDLE; they go to DONE next cycle (latency 1):
  - op2==0: quotient = all-ones (-1 / 0xFFFFFFFF); remainder = op1.
  - Signed op1==0x80000000 with op2==0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- Otherwise go to CALC with counter=XLEN and remainder register cleared.
- CALC, each cycle:
  - Shift {rem, quo} left 1.
  - Trial subtract divisor from rem; if non-negative, commit it and set quo[0]=1.
  - Decrement counter; when counter reaches 1, go to FIXUP (exactly XLEN CALC cycles).
- FIXUP:
  - Negate quotient if neg_q; negate remainder if neg_r.
  - Select the quotient (op[1]=0) or the remainder (op[1]=1) into the result register.
  - Go to DONE.
- DONE:
  - done=1 and result valid for exactly one cycle.
  - Unconditionally return to IDLE.
  - start is ignored in DONE; the instruction leaves exec at the end of this cycle.
- stall_req = (IDLE & start & ~flush) | CALC | FIXUP. It is 0 in DONE, so the pipeline advances on the done cycle.
- Normal latency: start sampled at cycle 0, done at cycle XLEN+2 (34 for XLEN=32). Total stall of XLEN+2 cycles.
- flush:
  - In any state, flush=1 forces IDLE next cycle with done=0; result holds its last value.
  - flush has priority over start in IDLE.
  - flush in DONE has no effect beyond the return to IDLE.
- result holds its value outside DONE; consumers qualify it with done.
- Arithmetic is modulo 2^XLEN. Negation is two's complement. Magnitude of 0x80000000 is 0x80000000, treated as unsigned.

Test Plan:
- DIVU 100/7 (op=01): stall_req high from cycle 0 through cycle 33; done=1 at cycle 34 with result=14; stall_req=0 at cycle 34.
- REM -7/2 (op=10, op1=0xFFFFFFF9, op2=2): result=0xFFFFFFFF (-1) at cycle 34. DIV with the same operands gives 0xFFFFFFFD (-3).
- Divide by zero: DIV 5/0 gives result=0xFFFFFFFF with done at cycle 1. REMU 5/0 gives result=5 at cycle 1. stall_req high at cycle 0 only.
- Signed overflow: DIV 0x80000000/0xFFFFFFFF gives 0x80000000 at cycle 1. REM with the same operands gives 0.
- Flush at cycle 10 of DIVU 1000/3: state returns to IDLE at cycle 11; done never asserts. A new start at cycle 12 with DIVU 9/3 gives done at cycle 46 with result=3.
- resetn pulsed low asynchronously mid-CALC: done, stall_req and result go to 0 immediately; after release, a new DIVU 0xFFFFFFFF/1 returns 0xFFFFFFFF at latency 34.
